// File: rtl/magnetron_potencia.sv
// Magnetron enable with PWM power levels, door-open pause and stop/clear handling.
// Optional ramp-up of the effective power level is enabled with `define SOFT_START_EN.
module magnetron_potencia #(
    parameter int NIVEIS      = 10,
    parameter int SLOT_CICLOS = 4,
    parameter int NW          = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          comecan,
    input  logic          paren,
    input  logic          limpan,
    input  logic          portafechada,
    input  logic          tdone,
    input  logic [NW-1:0] nivel,
    output logic          m_on,
    output logic          ativo,
    output logic          pausado
);

    localparam int P  = NIVEIS * SLOT_CICLOS;
    localparam int CW = $clog2(P);
    localparam int PW = $clog2(P + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(P - 1);
    localparam logic [NW-1:0] NIV_MAX = NW'(NIVEIS);
    localparam logic [PW-1:0] SLOT    = PW'(SLOT_CICLOS);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        AQUECENDO = 2'd1,
        PAUSADO   = 2'd2
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] nivel_lat_q, nivel_lat_d;
    logic [NW-1:0] nivel_eff_d;
    logic [NW-1:0] nivel_clamp;
    logic          comecan_q;
    logic          m_on_r_q, m_on_r_d;
    logic          ativo_q, pausado_q;
    logic          press, parar;

`ifdef SOFT_START_EN
    logic [NW-1:0] nivel_eff_q;
    logic          entra, wrap;
`endif

    always_comb begin
        nivel_clamp = (nivel > NIV_MAX) ? NIV_MAX : nivel;
        press       = comecan_q & ~comecan;
        parar       = ~paren | ~limpan | tdone;

        estado_d    = estado_q;
        cnt_d       = cnt_q;
        nivel_lat_d = nivel_lat_q;

        // Stop/clear/timer beats door and start press from every state.
        if (parar) begin
            estado_d = OCIOSO;
            cnt_d    = '0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    cnt_d = '0;
                    if (press && portafechada && (nivel != '0)) begin
                        estado_d    = AQUECENDO;
                        nivel_lat_d = nivel_clamp;
                    end
                end
                AQUECENDO: begin
                    if (!portafechada) begin
                        estado_d = PAUSADO;
                        cnt_d    = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d       = '0;
                        nivel_lat_d = nivel_clamp;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PAUSADO: begin
                    cnt_d = '0;
                    if (press && portafechada) begin
                        estado_d    = AQUECENDO;
                        nivel_lat_d = nivel_clamp;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end
            endcase
        end

`ifdef SOFT_START_EN
        entra = (estado_d == AQUECENDO) && (estado_q != AQUECENDO);
        wrap  = (estado_d == AQUECENDO) && (estado_q == AQUECENDO) && (cnt_q == CNT_MAX);
        // Ramp climbs one step per period wrap; a lowered level is followed at the wrap.
        if (estado_d != AQUECENDO) begin
            nivel_eff_d = '0;
        end else if (entra) begin
            nivel_eff_d = (nivel_lat_d != '0) ? NW'(1) : '0;
        end else if (wrap) begin
            nivel_eff_d = (nivel_eff_q < nivel_lat_d) ? (nivel_eff_q + NW'(1)) : nivel_lat_d;
        end else begin
            nivel_eff_d = nivel_eff_q;
        end
`else
        nivel_eff_d = nivel_lat_d;
`endif

        // Computed from next-state values so the registered PWM lines up with cnt_q.
        m_on_r_d = (estado_d == AQUECENDO) &&
                   (PW'(cnt_d) < (PW'(nivel_eff_d) * SLOT));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            estado_q    <= OCIOSO;
            cnt_q       <= '0;
            nivel_lat_q <= '0;
            comecan_q   <= 1'b1;
            m_on_r_q    <= 1'b0;
            ativo_q     <= 1'b0;
            pausado_q   <= 1'b0;
`ifdef SOFT_START_EN
            nivel_eff_q <= '0;
`endif
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            nivel_lat_q <= nivel_lat_d;
            comecan_q   <= comecan;
            m_on_r_q    <= m_on_r_d;
            ativo_q     <= (estado_d == AQUECENDO);
            pausado_q   <= (estado_d == PAUSADO);
`ifdef SOFT_START_EN
            nivel_eff_q <= nivel_eff_d;
`endif
        end
    end

    // Door gating stays combinational so the magnetron drops in the cycle the door opens.
    assign m_on    = m_on_r_q & portafechada & (estado_q == AQUECENDO);
    assign ativo   = ativo_q;
    assign pausado = pausado_q;

endmodule

// File: tb/tb_magnetron_potencia.sv
// Scoreboard bench for magnetron_potencia: stimulus pushes expected {m_on,ativo,pausado},
// a negedge monitor pops and compares.
module tb_magnetron_potencia;

    logic       clk = 1'b0;
    logic       resetn, comecan, paren, limpan, portafechada, tdone;
    logic [3:0] nivel;
    logic       m_on, ativo, pausado;

    logic       sResetn, sComecan, sParen, sLimpan, sDoor, sTdone;
    logic [3:0] sNivel;

    logic [2:0] expQ[$];
    string      nameQ[$];
    int         vectors     = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    magnetron_potencia #(
        .NIVEIS(10),
        .SLOT_CICLOS(4),
        .NW(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .comecan(comecan),
        .paren(paren),
        .limpan(limpan),
        .portafechada(portafechada),
        .tdone(tdone),
        .nivel(nivel),
        .m_on(m_on),
        .ativo(ativo),
        .pausado(pausado)
    );

    // Inputs change just after the edge; the expectation is for this cycle's negedge,
    // where registered outputs reflect the previous row's inputs.
    task automatic applyStimulus(input bit chk, input logic em, input logic ea,
                                 input logic ep, input string name);
        @(posedge clk);
        #1;
        resetn       = sResetn;
        comecan      = sComecan;
        paren        = sParen;
        limpan       = sLimpan;
        portafechada = sDoor;
        tdone        = sTdone;
        nivel        = sNivel;
        if (chk) begin
            expQ.push_back({em, ea, ep});
            nameQ.push_back(name);
        end
    endtask

    task automatic checkOutput(input logic [2:0] e, input string name);
        logic [2:0] act;
        act = {m_on, ativo, pausado};
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: m_on/ativo/pausado got %b, expected %b at %0t",
                     name, act, e, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front(), nameQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0; comecan = 1'b1; paren = 1'b1; limpan = 1'b1;
        portafechada = 1'b1; tdone = 1'b0; nivel = 4'd0;

        // Reset held for two cycles while other inputs toggle
        sResetn = 1'b0; sComecan = 1'b0; sParen = 1'b0; sLimpan = 1'b1;
        sDoor = 1'b1; sTdone = 1'b1; sNivel = 4'd5;
        applyStimulus(1, 0, 0, 0, "reset_c1");
        sComecan = 1'b1; sParen = 1'b1; sLimpan = 1'b0; sDoor = 1'b0;
        sTdone = 1'b0; sNivel = 4'd10;
        applyStimulus(1, 0, 0, 0, "reset_c2");
        sResetn = 1'b1; sComecan = 1'b1; sParen = 1'b1; sLimpan = 1'b1;
        sDoor = 1'b1; sTdone = 1'b0; sNivel = 4'd0;
        applyStimulus(1, 0, 0, 0, "reset_release");
        applyStimulus(1, 0, 0, 0, "idle_after_reset");

`ifndef SOFT_START_EN
        // Level 5: 20 high cycles per 40-cycle period
        sNivel = 4'd5; sComecan = 1'b0;
        applyStimulus(1, 0, 0, 0, "press_n5");
        sComecan = 1'b1;
        for (int j = 0; j < 80; j++) applyStimulus(1, (j % 40) < 20, 1, 0, "pwm_n5");

        // Door opens at cnt=7, closes, then a press resumes from cnt=0
        for (int j = 0; j < 7; j++) applyStimulus(1, 1, 1, 0, "pre_door");
        sDoor = 1'b0;
        applyStimulus(1, 0, 1, 0, "door_open_same_cycle");
        applyStimulus(1, 0, 0, 1, "paused");
        sDoor = 1'b1;
        applyStimulus(1, 0, 0, 1, "door_closed");
        applyStimulus(1, 0, 0, 1, "closed_no_resume");
        sComecan = 1'b0;
        applyStimulus(1, 0, 0, 1, "resume_press");
        sComecan = 1'b1;
        for (int j = 0; j < 40; j++) applyStimulus(1, j < 20, 1, 0, "resume_pwm");

        // Timer expiry
        sTdone = 1'b1;
        applyStimulus(1, 1, 1, 0, "tdone_row");
        sTdone = 1'b0;
        applyStimulus(1, 0, 0, 0, "tdone_stop");

        // Level 10: continuous across three wraps
        sNivel = 4'd10; sComecan = 1'b0;
        applyStimulus(1, 0, 0, 0, "press_n10");
        sComecan = 1'b1;
        for (int j = 0; j < 125; j++) applyStimulus(1, 1, 1, 0, "full_n10");

        // Stop while heating, then stop together with a press
        sParen = 1'b0;
        applyStimulus(1, 1, 1, 0, "paren_row");
        sParen = 1'b1;
        applyStimulus(1, 0, 0, 0, "paren_stop");
        sParen = 1'b0; sComecan = 1'b0;
        applyStimulus(1, 0, 0, 0, "paren_and_press");
        sParen = 1'b1; sComecan = 1'b1;
        applyStimulus(1, 0, 0, 0, "paren_press_idle");
        applyStimulus(1, 0, 0, 0, "paren_press_idle2");

        // Level 0 press is ignored
        sNivel = 4'd0; sComecan = 1'b0;
        applyStimulus(1, 0, 0, 0, "press_n0");
        sComecan = 1'b1;
        applyStimulus(1, 0, 0, 0, "n0_idle");
        applyStimulus(1, 0, 0, 0, "n0_idle2");

        // Level 5 -> 8 at cnt=10 takes effect at the next period
        sNivel = 4'd5; sComecan = 1'b0;
        applyStimulus(1, 0, 0, 0, "press_n5b");
        sComecan = 1'b1;
        for (int j = 0; j < 80; j++) begin
            if (j == 10) sNivel = 4'd8;
            applyStimulus(1, (j < 40) ? (j < 20) : ((j - 40) < 32), 1, 0, "level_change");
        end

        // Clear button stops heating
        sLimpan = 1'b0;
        applyStimulus(1, 1, 1, 0, "limpan_row");
        sLimpan = 1'b1;
        applyStimulus(1, 0, 0, 0, "limpan_stop");
`else
        // Soft start with level 3: 4, 8, 12, 12 high cycles
        sNivel = 4'd3; sComecan = 1'b0;
        applyStimulus(1, 0, 0, 0, "press_n3");
        sComecan = 1'b1;
        for (int j = 0; j < 160; j++)
            applyStimulus(1, (j % 40) < (((j / 40) < 2) ? ((j / 40) + 1) * 4 : 12), 1, 0,
                          "soft_ramp");

        // Pausing restarts the ramp
        sDoor = 1'b0;
        applyStimulus(1, 0, 1, 0, "soft_door_open");
        applyStimulus(1, 0, 0, 1, "soft_paused");
        sDoor = 1'b1; sComecan = 1'b0;
        applyStimulus(1, 0, 0, 1, "soft_resume_press");
        sComecan = 1'b1;
        for (int j = 0; j < 40; j++) applyStimulus(1, j < 4, 1, 0, "soft_restart");
`endif

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
